// File: rtl/sdram_burst_splitter.sv
// Splits host bursts into controller bursts of at most BURST_MAX words that never cross a page.
// Optional SDRAM_SPLIT_RDREG_EN: registers host read data/valid, adding one cycle of read latency.
module sdram_burst_splitter #(
    parameter int WORD_WIDTH     = 1,
    parameter int COL_WIDTH      = 9,
    parameter int BANK_WIDTH     = 2,
    parameter int ROW_WIDTH      = 13,
    parameter int BURST_MAX      = 64,
    parameter int HOST_BURST_MAX = 256,
    localparam int ADDR_WIDTH    = WORD_WIDTH + COL_WIDTH + BANK_WIDTH + ROW_WIDTH,
    localparam int BYTE_AMOUNT   = 2 ** WORD_WIDTH,
    localparam int DATA_W        = 8 * BYTE_AMOUNT,
    localparam int HBC_W         = $clog2(HOST_BURST_MAX) + 1,
    localparam int DBC_W         = $clog2(BURST_MAX) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_done,
    input  logic [ADDR_WIDTH-1:0]  host_address,
    input  logic [HBC_W-1:0]       host_burstcount,
    input  logic                   host_read,
    input  logic                   host_write,
    input  logic [DATA_W-1:0]      host_writedata,
    input  logic [BYTE_AMOUNT-1:0] host_byteenable,
    output logic                   host_waitrequest,
    output logic [DATA_W-1:0]      host_readdata,
    output logic                   host_readdatavalid,
    output logic [ADDR_WIDTH-1:0]  dbus_address,
    output logic [DBC_W-1:0]       dbus_burstcount,
    output logic                   dbus_read,
    output logic                   dbus_write,
    output logic [DATA_W-1:0]      dbus_writedata,
    output logic [BYTE_AMOUNT-1:0] dbus_byteenable,
    input  logic                   dbus_waitrequest,
    input  logic [DATA_W-1:0]      dbus_readdata,
    input  logic                   dbus_readdatavalid
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr, addr_nxt, step_addr;
    logic [HBC_W-1:0]        remaining, rem_nxt, step_rem, host_bc1;
    logic [DBC_W-1:0]        chunk, chunk_nxt, beats, beats_nxt;
`ifdef SDRAM_SPLIT_RDREG_EN
    logic                    drain, drain_nxt;
    logic                    rdv_q;
    logic [DATA_W-1:0]       rd_q;
`endif

    // Words that fit before the end of the current page, the burst limit and what is left.
    function automatic logic [DBC_W-1:0] chunk_of(input logic [ADDR_WIDTH-1:0] a,
                                                  input logic [HBC_W-1:0] rem);
        int room;
        int c;
        room = (1 << COL_WIDTH) - int'(a[WORD_WIDTH+COL_WIDTH-1:WORD_WIDTH]);
        c    = int'(rem);
        if (BURST_MAX < c) c = BURST_MAX;
        if (room < c) c = room;
        return c[DBC_W-1:0];
    endfunction

    assign host_bc1        = (host_burstcount == '0) ? HBC_W'(1) : host_burstcount;
    assign step_addr       = cur_addr + (ADDR_WIDTH'(chunk) << WORD_WIDTH);
    assign step_rem        = remaining - HBC_W'(chunk);
    assign dbus_address    = cur_addr;
    assign dbus_burstcount = chunk;
    assign dbus_writedata  = host_writedata;
    assign dbus_byteenable = host_byteenable;

    always_comb begin
        state_nxt        = state;
        addr_nxt         = cur_addr;
        rem_nxt          = remaining;
        chunk_nxt        = chunk;
        beats_nxt        = beats;
        dbus_read        = 1'b0;
        dbus_write       = 1'b0;
        host_waitrequest = 1'b1;
`ifdef SDRAM_SPLIT_RDREG_EN
        drain_nxt        = drain;
`endif
        case (state)
            IDLE: begin
                if (init_done && (host_read || host_write)) begin
                    addr_nxt  = host_address;
                    rem_nxt   = host_bc1;
                    chunk_nxt = chunk_of(host_address, host_bc1);
                    state_nxt = host_read ? RD_REQ : WR_REQ;
                end
            end
            RD_REQ: begin
                dbus_read = 1'b1;
                if (!dbus_waitrequest) begin
                    beats_nxt = chunk;
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
`ifdef SDRAM_SPLIT_RDREG_EN
                if (drain) begin
                    drain_nxt = 1'b0;
                    state_nxt = IDLE;
                end else
`endif
                if (dbus_readdatavalid) begin
                    beats_nxt = beats - 1'b1;
                    if (beats == DBC_W'(1)) begin
                        addr_nxt  = step_addr;
                        rem_nxt   = step_rem;
                        chunk_nxt = chunk_of(step_addr, step_rem);
                        if (step_rem != '0) state_nxt = RD_REQ;
`ifdef SDRAM_SPLIT_RDREG_EN
                        else drain_nxt = 1'b1;
`else
                        else state_nxt = IDLE;
`endif
                    end
                end
            end
            WR_REQ: begin
                dbus_write = 1'b1;
                if (!dbus_waitrequest) begin
                    beats_nxt = chunk;
                    state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                dbus_write       = host_write;
                host_waitrequest = dbus_waitrequest;
                if (host_write && !dbus_waitrequest) begin
                    beats_nxt = beats - 1'b1;
                    if (beats == DBC_W'(1)) begin
                        addr_nxt  = step_addr;
                        rem_nxt   = step_rem;
                        chunk_nxt = chunk_of(step_addr, step_rem);
                        state_nxt = (step_rem != '0) ? WR_REQ : IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            chunk     <= '0;
            beats     <= '0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= addr_nxt;
            remaining <= rem_nxt;
            chunk     <= chunk_nxt;
            beats     <= beats_nxt;
        end
    end

`ifdef SDRAM_SPLIT_RDREG_EN
    // Drain cycle keeps RD_DATA alive so the final registered beat is out before IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain <= 1'b0;
            rdv_q <= 1'b0;
            rd_q  <= '0;
        end else begin
            drain <= drain_nxt;
            rdv_q <= (state == RD_DATA) && !drain && dbus_readdatavalid;
            rd_q  <= dbus_readdata;
        end
    end

    assign host_readdata      = rd_q;
    assign host_readdatavalid = rdv_q;
`else
    assign host_readdata      = dbus_readdata;
    assign host_readdatavalid = (state == RD_DATA) && dbus_readdatavalid;
`endif

endmodule

// File: tb/tb_sdram_burst_splitter.sv
// Directed bench for sdram_burst_splitter with a behavioural controller slave and bus monitor.
module tb_sdram_burst_splitter;
    localparam int AW  = 25;
    localparam int DW  = 16;
    localparam int BA  = 2;
    localparam int HBW = 9;
    localparam int DBW = 7;
`ifdef SDRAM_SPLIT_RDREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic           clk = 1'b0, rst = 1'b1, init_done = 1'b0;
    logic [AW-1:0]  host_address = '0;
    logic [HBW-1:0] host_burstcount = '0;
    logic           host_read = 1'b0, host_write = 1'b0;
    logic [DW-1:0]  host_writedata = '0;
    logic [BA-1:0]  host_byteenable = '0;
    logic           host_waitrequest, host_readdatavalid;
    logic [DW-1:0]  host_readdata;
    logic [AW-1:0]  dbus_address;
    logic [DBW-1:0] dbus_burstcount;
    logic           dbus_read, dbus_write;
    logic [DW-1:0]  dbus_writedata;
    logic [BA-1:0]  dbus_byteenable;
    logic           dbus_waitrequest = 1'b0, dbus_readdatavalid = 1'b0;
    logic [DW-1:0]  dbus_readdata = '0;

    int n_cmp = 0, n_bad = 0, cyc = 0, gap = 0;

    logic [AW-1:0] cmd_addr[$];
    int            cmd_bc[$];
    bit            cmd_wr[$];
    logic [DW-1:0] hb_data[$], wb_data[$];
    int            hb_cyc[$], db_cyc[$];
    logic [23:0]   rdq[$];

    sdram_burst_splitter dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .host_address(host_address), .host_burstcount(host_burstcount),
        .host_read(host_read), .host_write(host_write),
        .host_writedata(host_writedata), .host_byteenable(host_byteenable),
        .host_waitrequest(host_waitrequest), .host_readdata(host_readdata),
        .host_readdatavalid(host_readdatavalid),
        .dbus_address(dbus_address), .dbus_burstcount(dbus_burstcount),
        .dbus_read(dbus_read), .dbus_write(dbus_write),
        .dbus_writedata(dbus_writedata), .dbus_byteenable(dbus_byteenable),
        .dbus_waitrequest(dbus_waitrequest), .dbus_readdata(dbus_readdata),
        .dbus_readdatavalid(dbus_readdatavalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] mdat(input logic [23:0] w);
        return w[15:0] ^ 16'hA5C3;
    endfunction

    // Monitor: inputs only change at posedge+1, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (!rst) begin
            if (dbus_read && !dbus_waitrequest) begin
                cmd_addr.push_back(dbus_address);
                cmd_bc.push_back(int'(dbus_burstcount));
                cmd_wr.push_back(1'b0);
                for (int i = 0; i < int'(dbus_burstcount); i++)
                    rdq.push_back(dbus_address[AW-1:1] + 24'(i));
            end
            if (dbus_write && !dbus_waitrequest && host_waitrequest) begin
                cmd_addr.push_back(dbus_address);
                cmd_bc.push_back(int'(dbus_burstcount));
                cmd_wr.push_back(1'b1);
            end
            if (dbus_write && !dbus_waitrequest && !host_waitrequest)
                wb_data.push_back(dbus_writedata);
            if (dbus_readdatavalid) db_cyc.push_back(cyc);
            if (host_readdatavalid) begin
                hb_data.push_back(host_readdata);
                hb_cyc.push_back(cyc);
            end
        end
    end

    // Controller read-data model: one beat per cycle, a bubble every fifth cycle.
    always @(posedge clk) begin
        if (rst) rdq.delete();
        #1;
        gap++;
        if (rdq.size() > 0 && (gap % 5) != 0) begin
            dbus_readdatavalid = 1'b1;
            dbus_readdata      = mdat(rdq.pop_front());
        end else begin
            dbus_readdatavalid = 1'b0;
            dbus_readdata      = '0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        cmd_addr.delete(); cmd_bc.delete(); cmd_wr.delete();
        hb_data.delete(); wb_data.delete(); hb_cyc.delete(); db_cyc.delete();
    endtask

    task automatic start_read(input logic [AW-1:0] a, input int n);
        host_address = a; host_burstcount = HBW'(n); host_read = 1'b1;
        tick(1);
        host_read = 1'b0;
    endtask

    task automatic wait_rd(input int n, output bit to);
        int k = 0;
        while (hb_data.size() < n && k < 3000) begin tick(1); k++; end
        tick(4);
        to = (hb_data.size() < n);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] wb,
                            input int st_at, input int st_len, output int hi, output bit to);
        int sent = 0, stl = 0, k = 0;
        hi = 0;
        host_address = a; host_burstcount = HBW'(n); host_write = 1'b1;
        host_writedata = wb; host_byteenable = 2'b10;
        while (sent < n && k < 3000) begin
            dbus_waitrequest = (sent == st_at) && (stl < st_len);
            @(negedge clk);
            if (dbus_waitrequest) begin
                stl++;
                if (host_waitrequest) hi++;
            end else if (!host_waitrequest) sent++;
            tick(1); k++;
            host_writedata = wb + 16'(sent);
        end
        host_write = 1'b0; dbus_waitrequest = 1'b0;
        to = (sent < n);
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(3);
        @(negedge clk);
        n_cmp++; if (host_waitrequest !== 1'b1) begin n_bad++; $display("FAIL reset_wait got %b want 1", host_waitrequest); end
        n_cmp++; if (dbus_read !== 1'b0) begin n_bad++; $display("FAIL reset_dbus_read got %b want 0", dbus_read); end
        n_cmp++; if (dbus_write !== 1'b0) begin n_bad++; $display("FAIL reset_dbus_write got %b want 0", dbus_write); end
        n_cmp++; if (host_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL reset_rdv got %b want 0", host_readdatavalid); end
        tick(1); rst = 1'b0; tick(1);
    endtask

    task automatic test_init_gate();
        clear_logs();
        host_address = 25'h40; host_burstcount = 9'd4; host_read = 1'b1;
        tick(6);
        host_read = 1'b0;
        n_cmp++; if (cmd_addr.size() != 0) begin n_bad++; $display("FAIL init_gate cmds got %0d want 0", cmd_addr.size()); end
        init_done = 1'b1; tick(1);
    endtask

    task automatic test_read_split();
        logic [AW-1:0] c_addr [5] = '{25'h0, 25'h0, 25'h20, 25'h1FFFFFC, 25'h3FE};
        int            c_cnt  [5] = '{16, 200, 0, 4, 3};
        int            c_beat [5] = '{16, 200, 1, 4, 3};
        int            c_nch  [5] = '{1, 4, 1, 2, 2};
        logic [AW-1:0] ch_a [5][4] = '{'{25'h0, 0, 0, 0}, '{25'h0, 25'h80, 25'h100, 25'h180},
                                       '{25'h20, 0, 0, 0}, '{25'h1FFFFFC, 25'h0, 0, 0},
                                       '{25'h3FE, 25'h400, 0, 0}};
        int            ch_b [5][4] = '{'{16, 0, 0, 0}, '{64, 64, 64, 8}, '{1, 0, 0, 0},
                                       '{2, 2, 0, 0}, '{1, 2, 0, 0}};
        bit to;
        logic [23:0] w;
        for (int c = 0; c < 5; c++) begin
            clear_logs();
            start_read(c_addr[c], c_cnt[c]);
            wait_rd(c_beat[c], to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL rd%0d_timeout got %0d beats want %0d", c, hb_data.size(), c_beat[c]); end
            n_cmp++; if (cmd_addr.size() != c_nch[c]) begin n_bad++; $display("FAIL rd%0d_nchunks got %0d want %0d", c, cmd_addr.size(), c_nch[c]); end
            for (int i = 0; i < c_nch[c] && i < cmd_addr.size(); i++) begin
                n_cmp++;
                if (cmd_addr[i] !== ch_a[c][i] || cmd_bc[i] != ch_b[c][i] || cmd_wr[i] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rd%0d_chunk%0d got addr %h bc %0d wr %b want addr %h bc %0d wr 0",
                             c, i, cmd_addr[i], cmd_bc[i], cmd_wr[i], ch_a[c][i], ch_b[c][i]);
                end
            end
            n_cmp++; if (hb_data.size() != c_beat[c]) begin n_bad++; $display("FAIL rd%0d_beats got %0d want %0d", c, hb_data.size(), c_beat[c]); end
            for (int i = 0; i < hb_data.size() && i < c_beat[c]; i++) begin
                w = c_addr[c][AW-1:1] + 24'(i);
                n_cmp++;
                if (hb_data[i] !== mdat(w)) begin n_bad++; $display("FAIL rd%0d_data%0d got %h want %h", c, i, hb_data[i], mdat(w)); end
                if (i < db_cyc.size()) begin
                    n_cmp++;
                    if (hb_cyc[i] - db_cyc[i] != LAT) begin n_bad++; $display("FAIL rd%0d_lat%0d got %0d want %0d", c, i, hb_cyc[i] - db_cyc[i], LAT); end
                end
            end
            @(negedge clk);
            n_cmp++; if (dbus_read !== 1'b0 || host_waitrequest !== 1'b1) begin n_bad++; $display("FAIL rd%0d_idle got rd %b wait %b want 0 1", c, dbus_read, host_waitrequest); end
            tick(1);
        end
    endtask

    task automatic test_write_page_cross();
        int hi; bit to;
        clear_logs();
        do_write(25'h3E8, 20, 16'h1000, 0, 0, hi, to);
        tick(3);
        n_cmp++; if (to) begin n_bad++; $display("FAIL wpc_timeout got %0d beats want 20", wb_data.size()); end
        n_cmp++; if (cmd_addr.size() != 2) begin n_bad++; $display("FAIL wpc_nchunks got %0d want 2", cmd_addr.size()); end
        if (cmd_addr.size() >= 2) begin
            n_cmp++; if (cmd_addr[0] !== 25'h3E8 || cmd_bc[0] != 12 || cmd_wr[0] !== 1'b1) begin n_bad++; $display("FAIL wpc_chunk0 got %h %0d %b want 3e8 12 1", cmd_addr[0], cmd_bc[0], cmd_wr[0]); end
            n_cmp++; if (cmd_addr[1] !== 25'h400 || cmd_bc[1] != 8 || cmd_wr[1] !== 1'b1) begin n_bad++; $display("FAIL wpc_chunk1 got %h %0d %b want 400 8 1", cmd_addr[1], cmd_bc[1], cmd_wr[1]); end
        end
        n_cmp++; if (wb_data.size() != 20) begin n_bad++; $display("FAIL wpc_beats got %0d want 20", wb_data.size()); end
        for (int i = 0; i < wb_data.size() && i < 20; i++) begin
            n_cmp++; if (wb_data[i] !== 16'h1000 + 16'(i)) begin n_bad++; $display("FAIL wpc_data%0d got %h want %h", i, wb_data[i], 16'h1000 + 16'(i)); end
        end
        host_byteenable = 2'b01; #1;
        n_cmp++; if (dbus_byteenable !== 2'b01) begin n_bad++; $display("FAIL byteenable got %b want 01", dbus_byteenable); end
        tick(1);
    endtask

    task automatic test_write_stall();
        int hi; bit to;
        clear_logs();
        do_write(25'h100, 16, 16'h2000, 6, 5, hi, to);
        tick(3);
        n_cmp++; if (to) begin n_bad++; $display("FAIL wst_timeout got %0d beats want 16", wb_data.size()); end
        n_cmp++; if (hi != 5) begin n_bad++; $display("FAIL wst_wait_cycles got %0d want 5", hi); end
        n_cmp++; if (cmd_addr.size() != 1) begin n_bad++; $display("FAIL wst_nchunks got %0d want 1", cmd_addr.size()); end
        n_cmp++; if (wb_data.size() != 16) begin n_bad++; $display("FAIL wst_beats got %0d want 16", wb_data.size()); end
        for (int i = 0; i < wb_data.size() && i < 16; i++) begin
            n_cmp++; if (wb_data[i] !== 16'h2000 + 16'(i)) begin n_bad++; $display("FAIL wst_data%0d got %h want %h", i, wb_data[i], 16'h2000 + 16'(i)); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int k = 0; bit to;
        clear_logs();
        start_read(25'h0, 200);
        while (hb_data.size() < 80 && k < 3000) begin tick(1); k++; end
        n_cmp++; if (cmd_addr.size() != 2) begin n_bad++; $display("FAIL rmb_pre_chunks got %0d want 2", cmd_addr.size()); end
        rst = 1'b1; tick(1); rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (dbus_read !== 1'b0) begin n_bad++; $display("FAIL rmb_dbus_read got %b want 0", dbus_read); end
        n_cmp++; if (host_waitrequest !== 1'b1) begin n_bad++; $display("FAIL rmb_wait got %b want 1", host_waitrequest); end
        clear_logs();
        tick(10);
        n_cmp++; if (cmd_addr.size() != 0 || hb_data.size() != 0) begin n_bad++; $display("FAIL rmb_quiet got %0d cmds %0d beats want 0 0", cmd_addr.size(), hb_data.size()); end
        start_read(25'h200, 4);
        wait_rd(4, to);
        n_cmp++; if (to || cmd_addr.size() != 1) begin n_bad++; $display("FAIL rmb_new got %0d cmds %0d beats want 1 4", cmd_addr.size(), hb_data.size()); end
        if (cmd_addr.size() == 1) begin
            n_cmp++; if (cmd_addr[0] !== 25'h200 || cmd_bc[0] != 4) begin n_bad++; $display("FAIL rmb_new_cmd got %h %0d want 200 4", cmd_addr[0], cmd_bc[0]); end
        end
        for (int i = 0; i < hb_data.size() && i < 4; i++) begin
            n_cmp++; if (hb_data[i] !== mdat(24'h100 + 24'(i))) begin n_bad++; $display("FAIL rmb_data%0d got %h want %h", i, hb_data[i], mdat(24'h100 + 24'(i))); end
        end
    endtask

    initial begin
        test_reset();
        test_init_gate();
        test_read_split();
        test_write_page_cross();
        test_write_stall();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
